// File: rtl/vga_pkg.sv
// Shared constants and types for the frame-buffer port arbiter.
// A word holds eight 3-bit pixels, pixel 0 in the most significant bits.
package vga_pkg;
    localparam int ADDR_W         = 16;
    localparam int PIX_W          = 3;
    localparam int PIX_PER_WORD   = 8;
    localparam int DATA_W         = PIX_PER_WORD * PIX_W;
    localparam int WORDS_PER_LINE = 80;

    localparam logic [1:0] OP_RD_WORD = 2'b00;
    localparam logic [1:0] OP_WR_WORD = 2'b01;
    localparam logic [1:0] OP_WR_PIX  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RMW_RD,
        S_RMW_WT,
        S_RMW_WR
    } state_e;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_SCAN,
        TAG_HOST
    } tag_e;
endpackage

// File: rtl/vram_cmd_fifo.sv
// Host command FIFO with fall-through read and a registered ready flag.
// The caller only pushes while o_ready is high.
module vram_cmd_fifo #(
    parameter int W = 45,
    parameter int D = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_ready
);
    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_ready;
    logic          w_pop;

    assign o_empty = (r_cnt == '0);
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_ready = r_ready;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_push && !w_pop)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (!i_push && w_pop)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    // Ready is derived from the next count so it is exact yet still a flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != CW'(D));
        end
    end

    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/vram_port_arbiter.sv
// Port-A owner: scanout reads take every slot they ask for, the host command
// FSM (word read/write, pixel read-modify-write) uses the remaining slots.
module vram_port_arbiter #(
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int DATA_W = vga_pkg::DATA_W,
    parameter int PIX_W  = vga_pkg::PIX_W,
    parameter int RD_LAT = 1,
    parameter int FIFO_D = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_overrun,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [1:0]        host_op,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [2:0]        host_pix,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    import vga_pkg::*;

    localparam int CMD_W = 2 + 3 + ADDR_W + DATA_W;

    state_e            r_state, w_state_nxt;
    tag_e              r_tag [0:RD_LAT];
    logic [1:0]        r_op;
    logic [2:0]        r_pix;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_scan_d, r_overrun;
    logic              r_scan_rvalid, r_host_rvalid;
    logic [DATA_W-1:0] r_scan_rdata, r_host_rdata;
    logic              r_ram_en, r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    logic [CMD_W-1:0]  w_fifo_wdata, w_fifo_rdata;
    logic              w_fifo_empty, w_fifo_ready, w_push, w_pop;
    logic [1:0]        w_cmd_op;
    logic              w_host_go, w_host_we, w_host_ret;
    logic [DATA_W-1:0] w_merged;

    assign host_ready   = w_fifo_ready;
    assign w_push       = host_valid && w_fifo_ready;
    assign w_fifo_wdata = {host_op, host_pix, host_addr, host_wdata};
    assign w_cmd_op     = w_fifo_rdata[CMD_W-1 -: 2];
    assign w_host_ret   = (r_tag[RD_LAT] == TAG_HOST);

    assign scan_rvalid  = r_scan_rvalid;
    assign scan_rdata   = r_scan_rdata;
    assign scan_overrun = r_overrun;
    assign host_rvalid  = r_host_rvalid;
    assign host_rdata   = r_host_rdata;
    assign ram_en       = r_ram_en;
    assign ram_we       = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;

    vram_cmd_fifo #(.W(CMD_W), .D(FIFO_D)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_fifo_wdata),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_ready (w_fifo_ready)
    );

    always_comb begin
        w_merged = ram_rdata;
        for (int i = 0; i < DATA_W / PIX_W; i++)
            if (r_pix == 3'(i))
                w_merged[DATA_W-1-PIX_W*i -: PIX_W] = r_wdata[PIX_W-1:0];
    end

    // Any host issue state simply waits while scan_req owns the slot.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_host_go   = 1'b0;
        w_host_we   = 1'b0;
        case (r_state)
            S_IDLE: if (!w_fifo_empty) begin
                w_pop = 1'b1;
                case (w_cmd_op)
                    OP_RD_WORD, OP_WR_WORD: w_state_nxt = S_ISSUE;
                    OP_WR_PIX:              w_state_nxt = S_RMW_RD;
                    default:                w_state_nxt = S_IDLE;
                endcase
            end
            S_ISSUE: if (!scan_req) begin
                w_host_go   = 1'b1;
                w_host_we   = (r_op == OP_WR_WORD);
                w_state_nxt = w_host_we ? S_IDLE : S_WAIT;
            end
            S_WAIT:   if (w_host_ret) w_state_nxt = S_IDLE;
            S_RMW_RD: if (!scan_req) begin
                w_host_go   = 1'b1;
                w_state_nxt = S_RMW_WT;
            end
            S_RMW_WT: if (w_host_ret) w_state_nxt = S_RMW_WR;
            S_RMW_WR: if (!scan_req) begin
                w_host_go   = 1'b1;
                w_host_we   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= RD_LAT; i++) r_tag[i] <= TAG_NONE;
            r_op          <= '0;
            r_pix         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_scan_d      <= 1'b0;
            r_overrun     <= 1'b0;
            r_scan_rvalid <= 1'b0;
            r_scan_rdata  <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
        end else begin
            r_scan_d <= scan_req;
            if (scan_req && r_scan_d) r_overrun <= 1'b1;

            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_tag[0] <= TAG_NONE;
            if (scan_req) begin
                r_ram_en   <= 1'b1;
                r_ram_addr <= scan_addr;
                r_tag[0]   <= TAG_SCAN;
            end else if (w_host_go) begin
                r_ram_en    <= 1'b1;
                r_ram_we    <= w_host_we;
                r_ram_addr  <= r_addr;
                r_ram_wdata <= r_wdata;
                r_tag[0]    <= w_host_we ? TAG_NONE : TAG_HOST;
            end
            for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];

            r_scan_rvalid <= (r_tag[RD_LAT] == TAG_SCAN);
            if (r_tag[RD_LAT] == TAG_SCAN) r_scan_rdata <= ram_rdata;
            r_host_rvalid <= (r_state == S_WAIT) && w_host_ret;
            if ((r_state == S_WAIT) && w_host_ret) r_host_rdata <= ram_rdata;

            if (w_pop) begin
                r_op    <= w_cmd_op;
                r_pix   <= w_fifo_rdata[CMD_W-3 -: 3];
                r_addr  <= w_fifo_rdata[DATA_W +: ADDR_W];
                r_wdata <= w_fifo_rdata[DATA_W-1:0];
            end else if ((r_state == S_RMW_WT) && w_host_ret) begin
                r_wdata <= w_merged;
            end
        end
    end
endmodule
